nibble_serial_add: RTL and testbench

NIBBLE_SERIAL_ADD -- requirements
Module: nibble_serial_add

---
 rtl/nibble_serial_add_pkg.sv | 20 ++
 rtl/nibble_serial_add_adder4.sv | 22 ++
 rtl/nibble_serial_add.sv | 105 ++++++++++
 tb/tb_nibble_serial_add.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_add_pkg.sv
// Shared types and constants for the nibble-serial adder.
// The index width helper keeps the counter sized to the nibble count.
package nibble_serial_add_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Clamped to 1 so an illegal WIDTH still elaborates far enough to hit the width check.
  function automatic int idx_w(input int width);
    int w;
    w = $clog2(width / NIBBLE);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/nibble_serial_add_adder4.sv
// Structural 4-bit ripple-carry adder built from per-bit full adders.
module Adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;
  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    logic p;
    assign p      = a[i] ^ b[i];
    assign s[i]   = p ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & p);
  end

  assign co = c[4];

endmodule

// File: rtl/nibble_serial_add.sv
// WIDTH-bit adder that reuses one 4-bit ripple adder over WIDTH/4 cycles,
// least significant nibble first, with valid/ready handshakes on both sides.
module nibble_serial_add
  import nibble_serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NN = WIDTH / NIBBLE;
  localparam int IW = idx_w(WIDTH);

  if ((WIDTH % NIBBLE) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_add: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t                       state;
  logic [IW-1:0]                idx;
  logic                         carry;
  logic [NN-1:0][NIBBLE-1:0]    a_q, b_q, res_q;
  logic                         out_valid_q;
  logic [NIBBLE-1:0]            add_s;
  logic                         add_co;
  logic                         a_msb, b_msb, r_msb;

  Adder4 u_add (
    .a  (a_q[idx]),
    .b  (b_q[idx]),
    .ci (carry),
    .s  (add_s),
    .co (add_co)
  );

  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q   <= a;
            b_q   <= b;
            carry <= c_in;
            idx   <= '0;
            res_q <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Final carry only lands in the carry register; it never wraps to bit 0.
          res_q[idx] <= add_s;
          carry      <= add_co;
          if (idx == IW'(NN - 1)) begin
            idx         <= '0;
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign a_msb = a_q[NN-1][NIBBLE-1];
  assign b_msb = b_q[NN-1][NIBBLE-1];
  assign r_msb = res_q[NN-1][NIBBLE-1];

  // Result outputs are gated so they read zero outside DONE.
  assign out_valid = out_valid_q;
  assign sum       = out_valid_q ? res_q : '0;
  assign c_out     = out_valid_q & carry;
  assign ovf       = out_valid_q & (a_msb == b_msb) & (r_msb != a_msb);

endmodule

// File: tb/tb_nibble_serial_add.sv
// Randomized and directed bench for nibble_serial_add against a cycle-level
// behavioural model plus literal expectations for the directed cases.
module tb_nibble_serial_add;

  localparam int W  = 16;
  localparam int NN = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  nibble_serial_add #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain wide addition.
  function automatic logic [W:0] ref_full(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] s);
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  // Behavioural model: accepted operands and a countdown to the result.
  logic [W-1:0] m_a = '0, m_b = '0;
  logic         m_c = 1'b0;
  bit           m_busy = 1'b0, m_done = 1'b0;
  int           m_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_busy && !m_done) begin
      if (in_valid) begin
        m_a    <= a;
        m_b    <= b;
        m_c    <= c_in;
        m_busy <= 1'b1;
        m_cnt  <= NN;
      end
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
    end else if (out_ready) begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [W:0] f;
      f = ref_full(m_a, m_b, m_c);
      chk("in_ready",  {63'd0, in_ready},  {63'd0, (!m_busy && !m_done && !rst)});
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_done});
      chk("sum",       {48'd0, sum},       m_done ? {48'd0, f[W-1:0]} : 64'd0);
      chk("c_out",     {63'd0, c_out},     m_done ? {63'd0, f[W]} : 64'd0);
      chk("ovf",       {63'd0, ovf},       m_done ? {63'd0, ref_ovf(m_a, m_b, f[W-1:0])} : 64'd0);
    end
  end

  // Caller is just after a clock edge with the block idle; this completes
  // the full operation including the result handshake.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input logic [W-1:0] es, input logic eco, input logic eov,
                       input int hold, input bit pulse);
    int n;
    logic [W-1:0] s0;
    logic co0;
    a = ta; b = tb_; c_in = tc; in_valid = 1'b1;
    chk("in_ready_before_op", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(NN));
    chk("lit_sum",   {48'd0, sum},   {48'd0, es});
    chk("lit_c_out", {63'd0, c_out}, {63'd0, eco});
    chk("lit_ovf",   {63'd0, ovf},   {63'd0, eov});
    s0 = sum; co0 = c_out;
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        in_valid = 1'b1; a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
      end
      @(posedge clk); #1;
      chk("hold_valid",    {63'd0, out_valid}, 64'd1);
      chk("hold_sum",      {48'd0, sum},       {48'd0, s0});
      chk("hold_c_out",    {63'd0, c_out},     {63'd0, co0});
      chk("hold_in_ready", {63'd0, in_ready},  64'd0);
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("after_ack_in_ready",  {63'd0, in_ready},  64'd1);
    chk("after_ack_out_valid", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    logic [W:0] f;
    logic [W-1:0] ra, rb;
    logic rc;
    #12;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_in_ready",  {63'd0, in_ready},  64'd0);
    chk("reset_sum",       {48'd0, sum},       64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1, 0, 1'b0);
    do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 5, 1'b1);

    // Abort an operation during its second RUN cycle.
    a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_sum",       {48'd0, sum},       64'd0);
    chk("abort_c_out",     {63'd0, c_out},     64'd0);
    chk("abort_in_ready",  {63'd0, in_ready},  64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 0, 1'b0);

    // Back-to-back and randomized traffic.
    for (int k = 0; k < 24; k++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      if (k % 6 == 0) rb = ~ra;
      f = ref_full(ra, rb, rc);
      do_op(ra, rb, rc, f[W-1:0], f[W], ref_ovf(ra, rb, f[W-1:0]),
            (k < 3) ? 0 : int'($urandom_range(0, 3)), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
